// File: rtl/cpu_trace_pkg.sv
// Shared types and ASCII constants for the CPU write-back trace emitter.
// The emitter walks one state per field of the frame; digit states loop internally.
package cpu_trace_pkg;

    typedef enum logic [3:0] {
        S_IDLE, S_CARET, S_TIME, S_AT, S_PC, S_COLON, S_SP1, S_SIGIL,
        S_ADDR, S_SP2, S_LT, S_EQ, S_SP3, S_DATA, S_HASH
    } state_t;

    localparam logic [7:0] CH_CARET  = 8'h5e;
    localparam logic [7:0] CH_AT     = 8'h40;
    localparam logic [7:0] CH_COLON  = 8'h3a;
    localparam logic [7:0] CH_SP     = 8'h20;
    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_STAR   = 8'h2a;
    localparam logic [7:0] CH_LT     = 8'h3c;
    localparam logic [7:0] CH_EQ     = 8'h3d;
    localparam logic [7:0] CH_HASH   = 8'h23;

    localparam logic [13:0] TIME_MAX = 14'd9999;

    localparam logic KIND_REG = 1'b0;
    localparam logic KIND_MEM = 1'b1;

endpackage

// File: rtl/trace_hex_ascii.sv
// Nibble to lowercase ASCII hex digit; also serves decimal digits 0-9.
module trace_hex_ascii (
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    always_comb begin
        if (nibble < 4'd10) ascii = 8'h30 + {4'd0, nibble};
        else                ascii = 8'h57 + {4'd0, nibble};
    end

endmodule

// File: rtl/cpu_trace_emitter.sv
// Serializes one trace record into "^time@pc: $reg <= data#" or "^time@pc: *addr <= data#".
// state | meaning
// IDLE  | waiting for a record, in_ready high
// CARET | '^'            TIME  | decimal time digits      AT    | '@'
// PC    | 8 hex digits   COLON | ':'                      SP1   | ' '
// SIGIL | '$' or '*'     ADDR  | reg decimal / 8 hex      SP2   | ' '
// LT    | '<'            EQ    | '='                      SP3   | ' '
// DATA  | 8 hex digits   HASH  | '#', frame end
module cpu_trace_emitter
    import cpu_trace_pkg::*;
#(
    parameter int TIME_W = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_kind,
    input  logic [TIME_W-1:0] in_time,
    input  logic [31:0]       in_pc,
    input  logic [31:0]       in_addr,
    input  logic [31:0]       in_data,
    output logic [7:0]        char_out,
    output logic              char_valid,
    input  logic              char_ready,
    output logic              char_last
);

    state_t      state, state_nx;
    logic [2:0]  idx;
    logic        rdy_q;
    logic        kind_q;
    logic [15:0] time_q;
    logic [2:0]  time_last;
    logic [31:0] pc_q, addr_q, data_q;
    logic [2:0]  addr_last;

    logic        fire, accept, multi, dig_last;
    logic [3:0]  nibble;
    logic [7:0]  hex_ch, char_c;
    logic        last_c;

    // Capture-time conversions: clamp + BCD for time, decimal split for reg index.
    logic [31:0] time_ext;
    logic [13:0] t_clamp;
    logic [3:0]  t_th, t_hu, t_te, t_on;
    logic [2:0]  t_last;
    logic [15:0] t_just;
    logic [4:0]  r_idx, r_ones;
    logic [3:0]  r_tens;

    assign time_ext = 32'(in_time);

    always_comb begin
        t_clamp = (time_ext > {18'd0, TIME_MAX}) ? TIME_MAX : time_ext[13:0];
        t_th    = 4'(t_clamp / 14'd1000);
        t_hu    = 4'((t_clamp / 14'd100) % 14'd10);
        t_te    = 4'((t_clamp / 14'd10) % 14'd10);
        t_on    = 4'(t_clamp % 14'd10);
        if      (t_clamp >= 14'd1000) t_last = 3'd3;
        else if (t_clamp >= 14'd100)  t_last = 3'd2;
        else if (t_clamp >= 14'd10)   t_last = 3'd1;
        else                          t_last = 3'd0;
        // Left-justify so the first printed digit is always the top nibble.
        t_just = {t_th, t_hu, t_te, t_on} << {3'd3 - t_last, 2'b00};

        r_idx = in_addr[4:0];
        if      (r_idx >= 5'd30) begin r_tens = 4'd3; r_ones = r_idx - 5'd30; end
        else if (r_idx >= 5'd20) begin r_tens = 4'd2; r_ones = r_idx - 5'd20; end
        else if (r_idx >= 5'd10) begin r_tens = 4'd1; r_ones = r_idx - 5'd10; end
        else                     begin r_tens = 4'd0; r_ones = r_idx;         end
    end

    logic [15:0] time_sh;
    logic [31:0] pc_sh, addr_sh, data_sh;
    assign time_sh = time_q << {idx, 2'b00};
    assign pc_sh   = pc_q   << {idx, 2'b00};
    assign addr_sh = addr_q << {idx, 2'b00};
    assign data_sh = data_q << {idx, 2'b00};

    trace_hex_ascii u_hex (
        .nibble (nibble),
        .ascii  (hex_ch)
    );

    assign fire   = (state != S_IDLE) && char_ready;
    assign accept = (state == S_IDLE) && in_valid && rdy_q;

    always_comb begin
        state_nx = state;
        nibble   = 4'd0;
        char_c   = 8'h00;
        last_c   = 1'b0;
        multi    = 1'b0;
        dig_last = 1'b0;
        case (state)
            S_IDLE:  if (accept) state_nx = S_CARET;
            S_CARET: begin char_c = CH_CARET; if (fire) state_nx = S_TIME; end
            S_TIME: begin
                multi    = 1'b1;
                nibble   = time_sh[15:12];
                char_c   = hex_ch;
                dig_last = (idx == time_last);
                if (fire && dig_last) state_nx = S_AT;
            end
            S_AT:    begin char_c = CH_AT; if (fire) state_nx = S_PC; end
            S_PC: begin
                multi    = 1'b1;
                nibble   = pc_sh[31:28];
                char_c   = hex_ch;
                dig_last = (idx == 3'd7);
                if (fire && dig_last) state_nx = S_COLON;
            end
            S_COLON: begin char_c = CH_COLON; if (fire) state_nx = S_SP1; end
            S_SP1:   begin char_c = CH_SP; if (fire) state_nx = S_SIGIL; end
            S_SIGIL: begin
                char_c = (kind_q == KIND_MEM) ? CH_STAR : CH_DOLLAR;
                if (fire) state_nx = S_ADDR;
            end
            S_ADDR: begin
                multi    = 1'b1;
                nibble   = addr_sh[31:28];
                char_c   = hex_ch;
                dig_last = (idx == addr_last);
                if (fire && dig_last) state_nx = S_SP2;
            end
            S_SP2:   begin char_c = CH_SP; if (fire) state_nx = S_LT; end
            S_LT:    begin char_c = CH_LT; if (fire) state_nx = S_EQ; end
            S_EQ:    begin char_c = CH_EQ; if (fire) state_nx = S_SP3; end
            S_SP3:   begin char_c = CH_SP; if (fire) state_nx = S_DATA; end
            S_DATA: begin
                multi    = 1'b1;
                nibble   = data_sh[31:28];
                char_c   = hex_ch;
                dig_last = (idx == 3'd7);
                if (fire && dig_last) state_nx = S_HASH;
            end
            S_HASH: begin
                char_c = CH_HASH;
                last_c = 1'b1;
                if (fire) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            idx       <= 3'd0;
            rdy_q     <= 1'b0;
            kind_q    <= KIND_REG;
            time_q    <= 16'd0;
            time_last <= 3'd0;
            pc_q      <= 32'd0;
            addr_q    <= 32'd0;
            addr_last <= 3'd0;
            data_q    <= 32'd0;
        end else begin
            state <= state_nx;
            rdy_q <= (state_nx == S_IDLE);
            if (fire) idx <= (multi && !dig_last) ? idx + 3'd1 : 3'd0;
            if (accept) begin
                kind_q    <= in_kind;
                time_q    <= t_just;
                time_last <= t_last;
                pc_q      <= in_pc;
                data_q    <= in_data;
                if (in_kind == KIND_MEM) begin
                    addr_q    <= in_addr;
                    addr_last <= 3'd7;
                end else if (r_tens == 4'd0) begin
                    addr_q    <= {r_ones[3:0], 28'd0};
                    addr_last <= 3'd0;
                end else begin
                    addr_q    <= {r_tens, r_ones[3:0], 24'd0};
                    addr_last <= 3'd1;
                end
            end
        end
    end

    assign in_ready   = rdy_q;
    assign char_valid = (state != S_IDLE);
    assign char_out   = char_c;
    assign char_last  = last_c;

endmodule

// File: tb/tb_cpu_trace_emitter.sv
// Directed checks of the trace emitter frame text, handshakes, stalls and reset.
module tb_cpu_trace_emitter;

    localparam int TW = 14;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic          in_kind;
    logic [TW-1:0] in_time;
    logic [31:0]   in_pc, in_addr, in_data;
    logic [7:0]    char_out;
    logic          char_valid;
    logic          char_ready;
    logic          char_last;

    int n_assert = 0;
    int n_fail   = 0;

    cpu_trace_emitter #(.TIME_W(TW)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_kind    (in_kind),
        .in_time    (in_time),
        .in_pc      (in_pc),
        .in_addr    (in_addr),
        .in_data    (in_data),
        .char_out   (char_out),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .char_last  (char_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_rec(input logic k, input logic [TW-1:0] t, input logic [31:0] pc,
                           input logic [31:0] a, input logic [31:0] d);
        in_kind = k; in_time = t; in_pc = pc; in_addr = a; in_data = d;
    endtask

    // Called at posedge+1 with in_valid high and in_ready high; the next edge accepts.
    // abort_after >= 0 returns once that many characters have been handshaked.
    task automatic run_frame(input string exp, input bit rnd, input bit scramble, input int abort_after);
        int  i   = 0;
        int  cyc = 0;
        bit  rdy;
        @(posedge clk); #1;
        if (!scramble) in_valid = 1'b0;
        while (i < exp.len() && cyc < 400) begin
            if (abort_after >= 0 && i == abort_after) return;
            rdy = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            char_ready = rdy;
            if (scramble) begin
                in_time = TW'($urandom);
                in_pc   = $urandom;
                in_addr = $urandom;
                in_data = $urandom;
            end
            chk("char_out",   32'(char_out),   32'(exp[i]));
            chk("char_valid", 32'(char_valid), 32'd1);
            chk("char_last",  32'(char_last),  32'(i == exp.len() - 1));
            chk("busy_ready", 32'(in_ready),   32'd0);
            @(posedge clk); #1;
            cyc++;
            if (rdy) i++;
        end
        chk("frame_timeout", 32'(cyc < 400), 32'd1);
        chk("end_valid", 32'(char_valid), 32'd0);
        chk("end_ready", 32'(in_ready),   32'd1);
        char_ready = 1'b1;
    endtask

    string s1, s2, s3;

    initial begin
        s1 = "^338@00003130: *00000088 <= ffffb528#";
        s2 = "^0@00003000: $31 <= 12345678#";
        s3 = "^9999@0000abcd: $5 <= deadbeef#";

        reset = 1'b0; in_valid = 1'b0; char_ready = 1'b1;
        set_rec(1'b0, '0, 32'd0, 32'd0, 32'd0);
        #1;
        chk("rst_ready", 32'(in_ready),   32'd0);
        chk("rst_valid", 32'(char_valid), 32'd0);
        chk("rst_char",  32'(char_out),   32'd0);
        chk("rst_last",  32'(char_last),  32'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        chk("rst_hold_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        chk("idle_ready", 32'(in_ready), 32'd1);
        chk("len_s1", 32'(s1.len()), 32'd37);

        // Memory record
        set_rec(1'b1, 14'd338, 32'h00003130, 32'h00000088, 32'hffffb528);
        in_valid = 1'b1;
        run_frame(s1, 1'b0, 1'b0, -1);

        // Register record, time 0, reg 31
        set_rec(1'b0, 14'd0, 32'h00003000, 32'd31, 32'h12345678);
        in_valid = 1'b1;
        run_frame(s2, 1'b0, 1'b0, -1);

        // Clamp and single-digit register
        set_rec(1'b0, 14'd12000, 32'h0000abcd, 32'hffffffe5, 32'hdeadbeef);
        in_valid = 1'b1;
        run_frame(s3, 1'b0, 1'b0, -1);

        // Backpressure
        set_rec(1'b1, 14'd338, 32'h00003130, 32'h00000088, 32'hffffb528);
        in_valid = 1'b1;
        run_frame(s1, 1'b1, 1'b0, -1);

        // Reset after the 10th character
        set_rec(1'b1, 14'd338, 32'h00003130, 32'h00000088, 32'hffffb528);
        in_valid = 1'b1;
        run_frame(s1, 1'b0, 1'b0, 10);
        chk("pre_abort_char", 32'(char_out), 32'(s1[10]));
        reset = 1'b0;
        #1;
        chk("abort_valid", 32'(char_valid), 32'd0);
        chk("abort_char",  32'(char_out),   32'd0);
        chk("abort_last",  32'(char_last),  32'd0);
        chk("abort_ready", 32'(in_ready),   32'd0);
        #12 reset = 1'b1;
        @(posedge clk); #1;
        chk("post_abort_ready", 32'(in_ready), 32'd1);
        set_rec(1'b0, 14'd0, 32'h00003000, 32'd31, 32'h12345678);
        in_valid = 1'b1;
        run_frame(s2, 1'b0, 1'b0, -1);

        // Held in_valid with fields changing mid-frame, then next record in IDLE
        set_rec(1'b0, 14'd12000, 32'h0000abcd, 32'd5, 32'hdeadbeef);
        in_valid = 1'b1;
        run_frame(s3, 1'b1, 1'b1, -1);
        set_rec(1'b0, 14'd0, 32'h00003000, 32'd31, 32'h12345678);
        run_frame(s2, 1'b0, 1'b0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
